// File: rtl/load_unit.sv
// Multicycle load sequencer between the MEM stage and a req/ack data-memory port.
// Issues word-aligned reads, then extracts and extends the big-endian byte/half/word.
module load_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 10
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        LoadReq,
  input  logic [31:0] Addr,
  input  logic [1:0]  Size,
  input  logic        Unsgnsel,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic [31:0] Data,
  output logic        Valid,
  output logic        Stall,
  output logic        AddrErr,
  output logic        BusErr
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_req_q, mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic             addr_err_q, addr_err_d;
  logic             bus_err_q, bus_err_d;
  logic [1:0]       off_q, off_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;

  logic             misaligned;
  logic             can_accept;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [31:0]      extracted;

  assign misaligned = (Size == 2'b11) ||
                      (Size == 2'b01 && Addr[0]) ||
                      (Size == 2'b10 && Addr[1:0] != 2'b00);
  assign can_accept = (state_q == IDLE) || (state_q == DONE);

  // Big-endian lane select: offset 0 is the most significant byte.
  always_comb begin
    sel_byte = 8'h00;
    case (off_q)
      2'd0:    sel_byte = MemRData[31:24];
      2'd1:    sel_byte = MemRData[23:16];
      2'd2:    sel_byte = MemRData[15:8];
      default: sel_byte = MemRData[7:0];
    endcase
    sel_half = off_q[1] ? MemRData[15:0] : MemRData[31:16];
    extracted = MemRData;
    case (size_q)
      2'b00:   extracted = uns_q ? {24'h000000, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      2'b01:   extracted = uns_q ? {16'h0000, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: extracted = MemRData;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    addr_err_d = 1'b0;
    bus_err_d  = 1'b0;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (LoadReq) begin
          if (misaligned) begin
            addr_err_d = 1'b1;
          end else begin
            state_d    = WAIT;
            mem_req_d  = 1'b1;
            mem_addr_d = {Addr[31:2], 2'b00};
            cnt_d      = '0;
            off_d      = Addr[1:0];
            size_d     = Size;
            uns_d      = Unsgnsel;
          end
        end
      end
      WAIT: begin
        // An ack arriving on the last permitted cycle still completes the load.
        if (MemAck) begin
          data_d    = extracted;
          valid_d   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      data_q     <= 32'h0;
      valid_q    <= 1'b0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
    end
  end

  assign MemReq  = mem_req_q;
  assign MemAddr = mem_addr_q;
  assign Data    = data_q;
  assign Valid   = valid_q;
  assign AddrErr = addr_err_q;
  assign BusErr  = bus_err_q;
  // Stall is forced low while reset is held.
  assign Stall   = nReset && ((state_q == WAIT) || (can_accept && LoadReq && !misaligned));

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: per-scenario tasks plus a load-data scoreboard.
module tb_load_unit;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        LoadReq = 1'b0;
  logic [31:0] Addr = 32'h0;
  logic [1:0]  Size = 2'b00;
  logic        Unsgnsel = 1'b0;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck = 1'b0;
  logic [31:0] MemRData = 32'h0;
  logic [31:0] Data;
  logic        Valid;
  logic        Stall;
  logic        AddrErr;
  logic        BusErr;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  load_unit #(.TIMEOUT(8), .CNT_W(4)) dut (
    .Clock(Clock), .nReset(nReset), .LoadReq(LoadReq), .Addr(Addr), .Size(Size),
    .Unsgnsel(Unsgnsel), .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck),
    .MemRData(MemRData), .Data(Data), .Valid(Valid), .Stall(Stall),
    .AddrErr(AddrErr), .BusErr(BusErr)
  );

  always #5 Clock = ~Clock;

  // Scoreboard: every Valid pulse must match the oldest outstanding expected result.
  always @(negedge Clock) begin
    if (Valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: Data=%h with no load outstanding", Data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (Data !== e) begin
          bad++;
          $display("FAIL load_data: got %h expected %h", Data, e);
        end else begin
          $display("load ok: Data=%h", Data);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clock); #1;
  endtask

  // Request cycle; returns one edge later with the unit in WAIT.
  task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic u);
    LoadReq = 1'b1; Addr = a; Size = s; Unsgnsel = u;
    @(negedge Clock);
    total++;
    if (Stall !== 1'b1 || MemReq !== 1'b0) begin
      bad++;
      $display("FAIL req_cycle: Stall=%b MemReq=%b expected 1/0", Stall, MemReq);
    end
    step();
    LoadReq = 1'b0;
  endtask

  // Holds MemAck low for waits cycles, acks with rdata, returns at start of DONE cycle.
  task automatic finish(input int waits, input logic [31:0] rdata, input logic [31:0] exp,
                        input logic [31:0] exp_addr);
    for (int i = 0; i < waits; i++) begin
      @(negedge Clock);
      total++;
      if (MemReq !== 1'b1 || Stall !== 1'b1 || MemAddr !== exp_addr || BusErr !== 1'b0) begin
        bad++;
        $display("FAIL wait_cycle%0d: MemReq=%b Stall=%b MemAddr=%h BusErr=%b expected 1/1/%h/0",
                 i, MemReq, Stall, MemAddr, BusErr, exp_addr);
      end
      step();
    end
    MemAck = 1'b1; MemRData = rdata;
    exp_q.push_back(exp);
    @(negedge Clock);
    total++;
    if (MemReq !== 1'b1 || Stall !== 1'b1) begin
      bad++;
      $display("FAIL ack_cycle: MemReq=%b Stall=%b expected 1/1", MemReq, Stall);
    end
    step();
    MemAck = 1'b0; MemRData = 32'h0;
  endtask

  task automatic check_done();
    @(negedge Clock);
    total++;
    if (Valid !== 1'b1 || MemReq !== 1'b0 || Stall !== 1'b0 || BusErr !== 1'b0) begin
      bad++;
      $display("FAIL done_cycle: Valid=%b MemReq=%b Stall=%b BusErr=%b expected 1/0/0/0",
               Valid, MemReq, Stall, BusErr);
    end
    step();
  endtask

  task automatic test_reset();
    nReset = 1'b0; LoadReq = 1'b1; Addr = 32'h100; Size = 2'b10;
    #3;
    total++;
    if (MemReq !== 1'b0 || MemAddr !== 32'h0 || Data !== 32'h0 || Valid !== 1'b0 ||
        AddrErr !== 1'b0 || BusErr !== 1'b0 || Stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: MemReq=%b MemAddr=%h Data=%h Valid=%b AddrErr=%b BusErr=%b Stall=%b expected all 0",
               MemReq, MemAddr, Data, Valid, AddrErr, BusErr, Stall);
    end
    LoadReq = 1'b0;
    step(); step();
    nReset = 1'b1;
    step();
  endtask

  task automatic test_byte_signed();
    issue(32'h1001, 2'b00, 1'b0);
    finish(3, 32'h12F45678, 32'hFFFFFFF4, 32'h1000);
    check_done();
    @(negedge Clock);
    total++;
    if (Data !== 32'hFFFFFFF4 || Valid !== 1'b0) begin
      bad++;
      $display("FAIL data_hold: Data=%h Valid=%b expected fffffff4/0", Data, Valid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    issue(32'h2002, 2'b01, 1'b1);
    finish(1, 32'hAAAA8001, 32'h00008001, 32'h2000);
    LoadReq = 1'b1; Addr = 32'h2004; Size = 2'b10; Unsgnsel = 1'b0;
    @(negedge Clock);
    total++;
    if (Valid !== 1'b1 || Stall !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done: Valid=%b Stall=%b expected 1/1", Valid, Stall);
    end
    step();
    LoadReq = 1'b0;
    @(negedge Clock);
    total++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h2004) begin
      bad++;
      $display("FAIL b2b_no_bubble: MemReq=%b MemAddr=%h expected 1/00002004", MemReq, MemAddr);
    end
    step();
    finish(0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h2004);
    check_done();
  endtask

  task automatic test_extract_mix();
    issue(32'h4003, 2'b00, 1'b1);
    finish(0, 32'h11223380, 32'h00000080, 32'h4000);
    check_done();
    issue(32'h4000, 2'b01, 1'b0);
    finish(2, 32'h9234ABCD, 32'hFFFF9234, 32'h4000);
    check_done();
    issue(32'h4002, 2'b00, 1'b0);
    finish(0, 32'h00007F00, 32'h0000007F, 32'h4000);
    check_done();
  endtask

  task automatic misaligned_case(input logic [31:0] a, input logic [1:0] s);
    LoadReq = 1'b1; Addr = a; Size = s;
    @(negedge Clock);
    total++;
    if (Stall !== 1'b0) begin
      bad++;
      $display("FAIL misalign_stall: Stall=%b expected 0 (size=%b)", Stall, s);
    end
    step();
    LoadReq = 1'b0;
    @(negedge Clock);
    total++;
    if (AddrErr !== 1'b1 || MemReq !== 1'b0 || Stall !== 1'b0) begin
      bad++;
      $display("FAIL misalign_err: AddrErr=%b MemReq=%b Stall=%b expected 1/0/0", AddrErr, MemReq, Stall);
    end
    step();
    @(negedge Clock);
    total++;
    if (AddrErr !== 1'b0 || MemReq !== 1'b0) begin
      bad++;
      $display("FAIL misalign_pulse: AddrErr=%b MemReq=%b expected 0/0", AddrErr, MemReq);
    end
    step();
  endtask

  task automatic test_misaligned();
    misaligned_case(32'h3002, 2'b10);
    misaligned_case(32'h3000, 2'b11);
    misaligned_case(32'h3001, 2'b01);
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int berr_cycles = 0;
    issue(32'h5000, 2'b10, 1'b0);
    for (int i = 0; i < 14; i++) begin
      @(negedge Clock);
      if (MemReq === 1'b1) req_cycles++;
      if (BusErr === 1'b1) berr_cycles++;
      step();
    end
    total++;
    if (req_cycles != 8 || berr_cycles != 1) begin
      bad++;
      $display("FAIL timeout: MemReq cycles=%0d BusErr cycles=%0d expected 8/1", req_cycles, berr_cycles);
    end
    issue(32'h5004, 2'b10, 1'b0);
    finish(7, 32'h0BADCAFE, 32'h0BADCAFE, 32'h5004);
    check_done();
  endtask

  task automatic test_reset_mid_op();
    issue(32'h6000, 2'b10, 1'b0);
    step();
    #2 nReset = 1'b0;
    #1;
    total++;
    if (MemReq !== 1'b0 || MemAddr !== 32'h0 || Data !== 32'h0 || Valid !== 1'b0 ||
        BusErr !== 1'b0 || AddrErr !== 1'b0 || Stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: MemReq=%b MemAddr=%h Data=%h Valid=%b BusErr=%b AddrErr=%b Stall=%b expected all 0",
               MemReq, MemAddr, Data, Valid, BusErr, AddrErr, Stall);
    end
    step(); step();
    nReset = 1'b1;
    MemAck = 1'b1; MemRData = 32'h55555555;
    step();
    MemAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      total++;
      if (Valid !== 1'b0 || MemReq !== 1'b0 || BusErr !== 1'b0) begin
        bad++;
        $display("FAIL late_ack: Valid=%b MemReq=%b BusErr=%b expected 0/0/0", Valid, MemReq, BusErr);
      end
      step();
    end
  endtask

  task automatic test_zero_wait();
    int lat = 0;
    LoadReq = 1'b1; Addr = 32'h7000; Size = 2'b10;
    step();
    LoadReq = 1'b0;
    MemAck = 1'b1; MemRData = 32'h13579BDF;
    exp_q.push_back(32'h13579BDF);
    step();
    MemAck = 1'b0;
    lat = 2;
    @(negedge Clock);
    total++;
    if (Valid !== 1'b1) begin
      bad++;
      $display("FAIL zero_wait: Valid=%b at %0d cycles after accept, expected 1", Valid, lat);
    end
    step();
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_byte_signed();
    test_back_to_back();
    test_extract_mix();
    test_misaligned();
    test_timeout();
    test_reset_mid_op();
    test_zero_wait();
    step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d loads never returned Valid, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
